// File: rtl/id_pkg.sv
// Shared decode constants for the id_pipe instruction-decode stage:
// opcode/funct encodings, ALU operation codes and result-class codes.
package id_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;

    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_SRA = 6'b000011;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;

    typedef enum logic [7:0] {
        EXE_NOP_OP = 8'h00,
        EXE_SRL_OP = 8'h02,
        EXE_SRA_OP = 8'h03,
        EXE_AND_OP = 8'h24,
        EXE_OR_OP  = 8'h25,
        EXE_XOR_OP = 8'h26,
        EXE_NOR_OP = 8'h27,
        EXE_SLL_OP = 8'h7C
    } aluop_e;

    typedef enum logic [2:0] {
        EXE_RES_NOP   = 3'd0,
        EXE_RES_LOGIC = 3'd1,
        EXE_RES_SHIFT = 3'd2
    } alusel_e;

    // True for the R-type logic functs that read both rs and rt.
    function automatic logic is_logic_funct(input logic [5:0] funct);
        is_logic_funct = (funct == FN_AND) || (funct == FN_OR) ||
                         (funct == FN_XOR) || (funct == FN_NOR);
    endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Per-port operand selector: immediate, hard-wired $0, optional EX/MEM
// bypass (ID_FORWARD_EN), then Regfile data.
module id_fwd_mux
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              re_i,
    input  logic [REG_AW-1:0] raddr_i,
    input  logic [DATA_W-1:0] rdata_i,
    input  logic              use_imm_i,
    input  logic [DATA_W-1:0] imm_i,
`ifdef ID_FORWARD_EN
    input  logic              ex_we_i,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
`endif
    output logic [DATA_W-1:0] operand_o
);

    // Operand priority: immediate, disabled/$0 read, EX, MEM, Regfile.
    always_comb begin
        operand_o = {DATA_W{1'b0}};
        if (use_imm_i) begin
            operand_o = imm_i;
        end else if (!re_i || (raddr_i == {REG_AW{1'b0}})) begin
            operand_o = {DATA_W{1'b0}};
`ifdef ID_FORWARD_EN
        end else if (ex_we_i && (ex_waddr_i == raddr_i)) begin
            operand_o = ex_wdata_i;
        end else if (mem_we_i && (mem_waddr_i == raddr_i)) begin
            operand_o = mem_wdata_i;
`endif
        end else begin
            operand_o = rdata_i;
        end
    end

endmodule

// File: rtl/id_pipe.sv
// Registered MIPS decode stage (logic/shift subset) with valid/ready
// handshake, flush and invalid flagging; ID_FORWARD_EN adds EX/MEM bypass.
module id_pipe
    import id_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [31:0]       inst_i,
    input  logic              flush_i,
    output logic              re1_o,
    output logic              re2_o,
    output logic [REG_AW-1:0] raddr1_o,
    output logic [REG_AW-1:0] raddr2_o,
    input  logic [DATA_W-1:0] rdata1_i,
    input  logic [DATA_W-1:0] rdata2_i,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] pc_o,
    output logic [7:0]        aluop_o,
    output logic [2:0]        alusel_o,
    output logic [DATA_W-1:0] data1_o,
    output logic [DATA_W-1:0] data2_o,
    output logic              we_o,
    output logic [REG_AW-1:0] waddr_o,
    output logic              inst_invalid_o
`ifdef ID_FORWARD_EN
    ,
    input  logic              ex_we_i,
    input  logic [REG_AW-1:0] ex_waddr_i,
    input  logic [DATA_W-1:0] ex_wdata_i,
    input  logic              mem_we_i,
    input  logic [REG_AW-1:0] mem_waddr_i,
    input  logic [DATA_W-1:0] mem_wdata_i
`endif
);

    logic [5:0]        op_s;
    logic [5:0]        funct_s;
    logic [REG_AW-1:0] rs_s;
    logic [REG_AW-1:0] rt_s;
    logic [REG_AW-1:0] rd_s;
    logic [4:0]        sa_s;
    logic [15:0]       imm_s;

    logic              dec_re1_s;
    logic              dec_re2_s;
    logic [REG_AW-1:0] dec_ra1_s;
    logic [REG_AW-1:0] dec_ra2_s;
    logic              dec_use_imm1_s;
    logic              dec_use_imm2_s;
    logic [DATA_W-1:0] dec_imm1_s;
    logic [DATA_W-1:0] dec_imm2_s;
    logic [7:0]        dec_aluop_s;
    logic [2:0]        dec_alusel_s;
    logic              dec_we_s;
    logic [REG_AW-1:0] dec_waddr_s;
    logic              dec_invalid_s;

    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;
    logic              accept_s;

    logic              out_valid_d, out_valid_q;
    logic [ADDR_W-1:0] pc_d, pc_q;
    logic [7:0]        aluop_d, aluop_q;
    logic [2:0]        alusel_d, alusel_q;
    logic [DATA_W-1:0] data1_d, data1_q;
    logic [DATA_W-1:0] data2_d, data2_q;
    logic              we_d, we_q;
    logic [REG_AW-1:0] waddr_d, waddr_q;
    logic              invalid_d, invalid_q;

    assign op_s    = inst_i[31:26];
    assign rs_s    = REG_AW'(inst_i[25:21]);
    assign rt_s    = REG_AW'(inst_i[20:16]);
    assign rd_s    = REG_AW'(inst_i[15:11]);
    assign sa_s    = inst_i[10:6];
    assign funct_s = inst_i[5:0];
    assign imm_s   = inst_i[15:0];

    // Instruction decode into read requests, immediates and EX controls.
    always_comb begin
        dec_re1_s      = 1'b0;
        dec_re2_s      = 1'b0;
        dec_ra1_s      = {REG_AW{1'b0}};
        dec_ra2_s      = {REG_AW{1'b0}};
        dec_use_imm1_s = 1'b0;
        dec_use_imm2_s = 1'b0;
        dec_imm1_s     = {DATA_W{1'b0}};
        dec_imm2_s     = {DATA_W{1'b0}};
        dec_aluop_s    = EXE_NOP_OP;
        dec_alusel_s   = EXE_RES_NOP;
        dec_we_s       = 1'b0;
        dec_waddr_s    = {REG_AW{1'b0}};
        dec_invalid_s  = 1'b0;
        case (op_s)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_re1_s      = 1'b1;
                dec_ra1_s      = rs_s;
                dec_use_imm2_s = 1'b1;
                dec_imm2_s     = DATA_W'(imm_s);
                dec_we_s       = 1'b1;
                dec_waddr_s    = rt_s;
                dec_alusel_s   = EXE_RES_LOGIC;
                case (op_s)
                    OP_ANDI: dec_aluop_s = EXE_AND_OP;
                    OP_XORI: dec_aluop_s = EXE_XOR_OP;
                    default: dec_aluop_s = EXE_OR_OP;
                endcase
            end
            OP_LUI: begin
                // Executed as 0 | {imm, 16'h0}, so no register read is needed.
                dec_use_imm1_s = 1'b1;
                dec_use_imm2_s = 1'b1;
                dec_imm2_s     = DATA_W'({imm_s, 16'h0000});
                dec_we_s       = 1'b1;
                dec_waddr_s    = rt_s;
                dec_aluop_s    = EXE_OR_OP;
                dec_alusel_s   = EXE_RES_LOGIC;
            end
            OP_SPECIAL: begin
                if (inst_i == 32'h0000_0000) begin
                    dec_aluop_s = EXE_NOP_OP;
                end else if (is_logic_funct(funct_s)) begin
                    dec_re1_s    = 1'b1;
                    dec_re2_s    = 1'b1;
                    dec_ra1_s    = rs_s;
                    dec_ra2_s    = rt_s;
                    dec_we_s     = 1'b1;
                    dec_waddr_s  = rd_s;
                    dec_alusel_s = EXE_RES_LOGIC;
                    case (funct_s)
                        FN_AND:  dec_aluop_s = EXE_AND_OP;
                        FN_OR:   dec_aluop_s = EXE_OR_OP;
                        FN_XOR:  dec_aluop_s = EXE_XOR_OP;
                        default: dec_aluop_s = EXE_NOR_OP;
                    endcase
                end else begin
                    case (funct_s)
                        FN_SLL, FN_SRL, FN_SRA: begin
                            dec_re2_s      = 1'b1;
                            dec_ra2_s      = rt_s;
                            dec_use_imm1_s = 1'b1;
                            dec_imm1_s     = DATA_W'(sa_s);
                            dec_we_s       = 1'b1;
                            dec_waddr_s    = rd_s;
                            dec_alusel_s   = EXE_RES_SHIFT;
                            case (funct_s)
                                FN_SRL:  dec_aluop_s = EXE_SRL_OP;
                                FN_SRA:  dec_aluop_s = EXE_SRA_OP;
                                default: dec_aluop_s = EXE_SLL_OP;
                            endcase
                        end
                        default: dec_invalid_s = 1'b1;
                    endcase
                end
            end
            default: dec_invalid_s = 1'b1;
        endcase
        if (dec_waddr_s == {REG_AW{1'b0}}) begin
            dec_we_s = 1'b0;
        end else begin
            dec_we_s = dec_we_s;
        end
    end

    // Regfile requests are suppressed when IF has nothing to offer.
    assign re1_o    = in_valid & dec_re1_s;
    assign re2_o    = in_valid & dec_re2_s;
    assign raddr1_o = in_valid ? dec_ra1_s : {REG_AW{1'b0}};
    assign raddr2_o = in_valid ? dec_ra2_s : {REG_AW{1'b0}};

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_op1 (
        .re_i        (re1_o),
        .raddr_i     (raddr1_o),
        .rdata_i     (rdata1_i),
        .use_imm_i   (dec_use_imm1_s),
        .imm_i       (dec_imm1_s),
`ifdef ID_FORWARD_EN
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .mem_we_i    (mem_we_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
`endif
        .operand_o   (op1_s)
    );

    id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_op2 (
        .re_i        (re2_o),
        .raddr_i     (raddr2_o),
        .rdata_i     (rdata2_i),
        .use_imm_i   (dec_use_imm2_s),
        .imm_i       (dec_imm2_s),
`ifdef ID_FORWARD_EN
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .mem_we_i    (mem_we_i),
        .mem_waddr_i (mem_waddr_i),
        .mem_wdata_i (mem_wdata_i),
`endif
        .operand_o   (op2_s)
    );

    assign in_ready = !out_valid_q | out_ready;
    assign accept_s = in_valid & in_ready & !flush_i;

    // Output register next state: flush beats accept, accept beats drain/hold.
    always_comb begin
        out_valid_d = out_valid_q;
        pc_d        = pc_q;
        aluop_d     = aluop_q;
        alusel_d    = alusel_q;
        data1_d     = data1_q;
        data2_d     = data2_q;
        we_d        = we_q;
        waddr_d     = waddr_q;
        invalid_d   = invalid_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            out_valid_d = 1'b1;
            pc_d        = pc_i;
            aluop_d     = dec_aluop_s;
            alusel_d    = dec_alusel_s;
            data1_d     = op1_s;
            data2_d     = op2_s;
            we_d        = dec_we_s;
            waddr_d     = dec_waddr_s;
            invalid_d   = dec_invalid_s;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output pipeline register toward EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            pc_q        <= {ADDR_W{1'b0}};
            aluop_q     <= EXE_NOP_OP;
            alusel_q    <= EXE_RES_NOP;
            data1_q     <= {DATA_W{1'b0}};
            data2_q     <= {DATA_W{1'b0}};
            we_q        <= 1'b0;
            waddr_q     <= {REG_AW{1'b0}};
            invalid_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            pc_q        <= pc_d;
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            data1_q     <= data1_d;
            data2_q     <= data2_d;
            we_q        <= we_d;
            waddr_q     <= waddr_d;
            invalid_q   <= invalid_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign pc_o           = pc_q;
    assign aluop_o        = aluop_q;
    assign alusel_o       = alusel_q;
    assign data1_o        = data1_q;
    assign data2_o        = data2_q;
    assign we_o           = we_q;
    assign waddr_o        = waddr_q;
    assign inst_invalid_o = invalid_q;

endmodule
